// File: rtl/mips_defs.sv
// Shared MIPS32 opcode and field-position constants.
// Used by the decode queue and by control.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic logic imm_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational MIPS32 field splitter for one instruction word.
// Produces all fields, extended immediate and jump target.
module instr_field_split
    import mips_defs::*;
#(
    parameter int PC_W = 32
) (
    input  logic [31:0]     word,
    input  logic [PC_W-1:0] pc,
    output logic [5:0]      op,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     immediate,
    output logic [31:0]     imm_ext,
    output logic [31:0]     jump_target
);

    logic [PC_W-1:0] pc_plus4;
    logic            unused_pc;

    assign op        = word[OP_MSB:OP_LSB];
    assign rs        = word[RS_MSB:RS_LSB];
    assign rt        = word[RT_MSB:RT_LSB];
    assign rd        = word[RD_MSB:RD_LSB];
    assign shamt     = word[SH_MSB:SH_LSB];
    assign funct     = word[FN_MSB:FN_LSB];
    assign immediate = word[IMM_MSB:IMM_LSB];

    always_comb begin
        imm_ext = {{16{immediate[15]}}, immediate};
        unique case (1'b1)
            imm_zext(op): imm_ext = {16'h0000, immediate};
            default:      imm_ext = {{16{immediate[15]}}, immediate};
        endcase
    end

    assign pc_plus4    = pc + PC_W'(4);
    assign jump_target = {pc_plus4[PC_W-1 -: 4], word[TGT_MSB:TGT_LSB], 2'b00};
    assign unused_pc   = ^pc_plus4[PC_W-5:0];

endmodule

// File: rtl/instr_decode_queue.sv
// Fetch-to-decode instruction queue with head-entry field decode.
// Registered occupancy drives in_ready/out_valid; no fall-through.
module instr_decode_queue
    import mips_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instruction,
    input  logic [PC_W-1:0]          pc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               op,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [5:0]               funct,
    output logic [15:0]              immediate,
    output logic [31:0]              imm_ext,
    output logic [31:0]              jump_target,
    output logic [PC_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;
    logic [31:0]     head_instr;

    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    // Storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_instr[wptr] <= instruction;
            mem_pc[wptr]    <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    assign head_instr = mem_instr[rptr];
    assign pc_out     = mem_pc[rptr];

    instr_field_split #(
        .PC_W(PC_W)
    ) u_split (
        .word        (head_instr),
        .pc          (pc_out),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .immediate   (immediate),
        .imm_ext     (imm_ext),
        .jump_target (jump_target)
    );

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (DEPTH=4).
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [31:0] imm_ext;
    logic [31:0] jump_target;
    logic [31:0] pc_out;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_decode_queue #(
        .DEPTH(DEPTH),
        .PC_W (PC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pc_in       (pc_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .immediate   (immediate),
        .imm_ext     (imm_ext),
        .jump_target (jump_target),
        .pc_out      (pc_out),
        .count       (count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] zt_instr [5];
    logic [31:0] zt_exp   [5];

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = '0;
        pc_in       = '0;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // lw $3, 4($2)
        instruction = 32'h8C430004;
        pc_in       = 32'h00400000;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lw_valid", 64'(out_valid), 64'd1);
        check("lw_op", 64'(op), 64'h23);
        check("lw_rs", 64'(rs), 64'd2);
        check("lw_rt", 64'(rt), 64'd3);
        check("lw_imm", 64'(immediate), 64'h0004);
        check("lw_immext", 64'(imm_ext), 64'h00000004);
        check("lw_count", 64'(count), 64'd1);
        check("lw_pc", 64'(pc_out), 64'h00400000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("lw_pop_count", 64'(count), 64'd0);
        check("lw_pop_valid", 64'(out_valid), 64'd0);

        // ORI then ADDI, both with 16'hFFFF
        instruction = 32'h3400FFFF;
        in_valid    = 1'b1;
        tick();
        instruction = 32'h2000FFFF;
        check("ori_immext", 64'(imm_ext), 64'h0000FFFF);
        tick();
        in_valid = 1'b0;
        check("two_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        tick();
        check("addi_immext", 64'(imm_ext), 64'hFFFFFFFF);
        check("addi_count", 64'(count), 64'd1);
        tick();
        out_ready = 1'b0;
        check("ext_empty", 64'(count), 64'd0);

        // extension boundary with immediate 16'h8000
        zt_instr[0] = 32'h30008000; zt_exp[0] = 32'h00008000;
        zt_instr[1] = 32'h34008000; zt_exp[1] = 32'h00008000;
        zt_instr[2] = 32'h38008000; zt_exp[2] = 32'h00008000;
        zt_instr[3] = 32'h3C008000; zt_exp[3] = 32'hFFFF8000;
        zt_instr[4] = 32'h00008000; zt_exp[4] = 32'hFFFF8000;
        for (int i = 0; i < 5; i++) begin
            instruction = zt_instr[i];
            in_valid    = 1'b1;
            tick();
            in_valid  = 1'b0;
            check($sformatf("ext_tbl%0d", i), 64'(imm_ext), 64'(zt_exp[i]));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // jump targets
        instruction = 32'h08100000;
        pc_in       = 32'h00400010;
        in_valid    = 1'b1;
        tick();
        instruction = 32'h0BFFFFFF;
        pc_in       = 32'hFFFFFFFC;
        tick();
        instruction = 32'h08000000;
        pc_in       = 32'hF0000000;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("j_target", 64'(jump_target), 64'h00400000);
        tick();
        check("j_wrap", 64'(jump_target), 64'h0FFFFFFC);
        tick();
        check("j_hi", 64'(jump_target), 64'hF0000000);
        tick();
        out_ready = 1'b0;

        // fill to DEPTH, refuse extra push, drain in order
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            instruction = 32'h10000000 + 32'(i);
            pc_in       = 32'h00000100 + 32'(4 * i);
            tick();
        end
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_ready", 64'(in_ready), 64'd0);
        instruction = 32'hDEADBEEF;
        pc_in       = 32'hDEAD0000;
        tick();
        check("full_refuse", 64'(count), 64'(DEPTH));
        out_ready = 1'b1;
        check("drain_pc0", 64'(pc_out), 64'h00000100);
        tick();
        in_valid = 1'b0;
        check("full_pop_refuse", 64'(count), 64'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain_pc%0d", i), 64'(pc_out),
                  64'(32'h00000100 + 32'(4 * i)));
            check($sformatf("drain_fn%0d", i), 64'(funct), 64'(i));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'd0);

        // streaming, one in one out per cycle
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        instruction = 32'h20000000;
        pc_in       = 32'h00001000;
        tick();
        for (int k = 1; k <= 20; k++) begin
            instruction = 32'h20000000 + 32'(k);
            pc_in       = 32'h00001000 + 32'(4 * k);
            check($sformatf("stream_cnt%0d", k), 64'(count), 64'd1);
            check($sformatf("stream_pc%0d", k), 64'(pc_out),
                  64'(32'h00001000 + 32'(4 * (k - 1))));
            check($sformatf("stream_imm%0d", k), 64'(immediate),
                  64'(k - 1));
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_empty", 64'(count), 64'd0);

        // flush with count=3 and a concurrent push
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction = 32'h30000000 + 32'(i);
            pc_in       = 32'h00002000 + 32'(4 * i);
            tick();
        end
        check("pre_flush_cnt", 64'(count), 64'd3);
        flush       = 1'b1;
        instruction = 32'h3000AAAA;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        instruction = 32'h3000BBBB;
        pc_in       = 32'h00003000;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_flush_imm", 64'(immediate), 64'hBBBB);
        check("post_flush_pc", 64'(pc_out), 64'h00003000);

        // async reset mid-stream
        in_valid    = 1'b1;
        instruction = 32'h3000CCCC;
        tick();
        in_valid = 1'b0;
        check("pre_rst_cnt", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        instruction = 32'h3000DDDD;
        pc_in       = 32'h00004000;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        check("resume_count", 64'(count), 64'd1);
        check("resume_imm", 64'(immediate), 64'hDDDD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Parametrised instruction buffer with integrated field decode, sitting between instruction fetch and the register-file/control stage of the MIPS32 core. It accepts fetched words with their PC over a valid/ready handshake, holds up to DEPTH entries, and presents the head entry already split into op/rs/rt/rd/shamt/funct/immediate. It also presents an extended immediate and a jump target. Supports pipeline flush and fetch/decode back-pressure, which a purely combinational field splitter cannot.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- PC_W, 32, PC width; fixed at 32 for MIPS32, kept as a parameter for the test harness
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  synchronous flush; drops all entries
- in_valid  in  1  fetch presents a word
- in_ready  out  1  queue can accept; equals !full
- instruction  in  32  fetched instruction word
- pc_in  in  PC_W  address of instruction
- out_valid  out  1  head entry valid; equals !empty
- out_ready  in  1  decode consumes head
- op  out  6  head[31:26]
- rs  out  5  head[25:21]
- rt  out  5  head[20:16]
- rd  out  5  head[15:11]
- shamt  out  5  head[10:6]
- funct  out  6  head[5:0]
- immediate  out  16  head[15:0]
- imm_ext  out  32  extended immediate (see Operation)
- jump_target  out  32  {pc_out+4 [31:28], head[25:0], 2'b00}
- pc_out  out  PC_W  PC of head entry
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: circular buffer of {instruction, pc}, with write pointer, read pointer and count registers. Pointers wrap modulo DEPTH.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready depends only on count. It has no combinational path from out_ready. When full, a push is refused even if a pop happens in the same cycle.
- Simultaneous push and pop when not full and not empty: both pointers advance and count is unchanged.
- Push into an empty queue: the entry appears at the outputs the next cycle. There is no fall-through.
- Decode is combinational on the head entry. All field outputs track the head. When out_valid=0 they show the stale slot and must be ignored.
- imm_ext is zero-extended for opcodes ANDI 6'h0C, ORI 6'h0D and XORI 6'h0E. It is sign-extended for all other opcodes.
- jump_target uses the head's pc_out+4. Addition wraps mod 2^32.
- flush: next cycle count=0 and pointers are 0. A push in the flush cycle is discarded. Flush wins over push and pop.

## Timing
- Reset: count=0, pointers=0, out_valid=0, in_ready=1. Storage is not reset. Field outputs decode slot 0 and are don't-care.
- Reset asserted mid-operation clears the queue immediately and asynchronously. Operation resumes on the first clk edge after rst_n rises.
- Latency: accept at edge N makes out_valid=1 from edge N+1.
- Throughput: one push and one pop per cycle.
- Full at count=DEPTH; in_ready=0 in the same cycle count reaches DEPTH.
- Empty at count=0; out_valid=0.
- All outputs are glitch-free relative to clk. There are no combinational paths from in_* to out_* or to in_ready.

## Structure
- Shared package/header mips_defs holds the opcode constants: OP_RTYPE 6'h00, OP_J 6'h02, OP_JAL 6'h03, OP_ANDI, OP_ORI, OP_XORI.
- Field bit positions are defined as constants in the same package and reused by control.
- Sub-module instr_field_split is purely combinational: word and pc in, every field plus imm_ext and jump_target out. It is instantiated once on the head entry.

## Test plan
- Reset then push 32'h8C430004 (lw) at pc 32'h00400000 -> next cycle out_valid=1, op=6'h23, rs=2, rt=3, immediate=16'h0004, imm_ext=32'h00000004, count=1.
- Push ORI with immediate 16'hFFFF, then ADDI with immediate 16'hFFFF -> imm_ext reads 32'h0000FFFF first, then 32'hFFFFFFFF.
- Push J with target field 26'h0100000 at pc 32'h00400010 -> jump_target=32'h00400000.
- Fill with DEPTH pushes while out_ready=0 -> in_ready=0 and count=DEPTH. An extra push is refused, and entries drain in order with correct pc_out.
- Streaming with in_valid=out_ready=1 for 20 cycles, wrapping pointers -> count stays 1 and the output sequence equals the input sequence delayed by one cycle.
- Flush with count=3 and in_valid=1 in the same cycle -> next cycle count=0 and out_valid=0. Assert rst_n=0 mid-stream -> out_valid=0 immediately.
